// File: rtl/fft_stage_index_gen.sv
// Radix-2 DIT index generator: per-position butterfly partner, twiddle exponent
// and upper-leg flag for the selected stage, all registered with one-cycle latency.
module fft_stage_index_gen #(
  parameter int unsigned SAMPLES = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [$clog2(SAMPLES)-1:0]      stage,
  output logic [SAMPLES-1:0][$clog2(SAMPLES)-1:0] display_stream,
  output logic [SAMPLES-1:0][$clog2(SAMPLES)-1:0] twiddle_stream,
  output logic [SAMPLES-1:0]              upper_mask,
  output logic                            stage_err
);

  localparam int unsigned LOG2 = $clog2(SAMPLES);

  logic                            stage_ok_c;
  logic [LOG2-1:0]                 leg_bit_c;
  logic [LOG2-1:0]                 low_mask_c;
  logic [LOG2-1:0]                 shamt_c;
  logic [SAMPLES-1:0][LOG2-1:0]    display_c;
  logic [SAMPLES-1:0][LOG2-1:0]    twiddle_c;
  logic [SAMPLES-1:0]              upper_c;

  // Next-stage index maps; only meaningful when stage_ok_c is set.
  // The twiddle product is a power of two, so it collapses to a shift.
  always_comb begin
    stage_ok_c = 32'(stage) < LOG2;
    leg_bit_c  = LOG2'(1) << stage;
    low_mask_c = leg_bit_c - LOG2'(1);
    shamt_c    = LOG2'(LOG2 - 1) - stage;
    display_c  = '0;
    twiddle_c  = '0;
    upper_c    = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      display_c[i] = LOG2'(i) ^ leg_bit_c;
      twiddle_c[i] = (LOG2'(i) & low_mask_c) << shamt_c;
      upper_c[i]   = ~|(LOG2'(i) & leg_bit_c);
    end
  end

  // Invalid stages keep the last map and only raise the error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SAMPLES; i++) begin
        display_stream[i] <= LOG2'(i);
      end
      twiddle_stream <= '0;
      upper_mask     <= '0;
      stage_err      <= 1'b0;
    end else begin
      stage_err <= ~stage_ok_c;
      if (stage_ok_c) begin
        display_stream <= display_c;
        twiddle_stream <= twiddle_c;
        upper_mask     <= upper_c;
      end
    end
  end

endmodule

// File: tb/tb_fft_stage_index_gen.sv
// Directed-vector bench for fft_stage_index_gen at SAMPLES=4: a per-edge vector
// table plus hand sequences for latency and stage-map properties.
module tb_fft_stage_index_gen;

  localparam int unsigned SAMPLES = 4;
  localparam int unsigned LOG2    = 2;

  typedef logic [SAMPLES-1:0][LOG2-1:0] arr_t;

  typedef struct {
    logic       rst_n;
    logic [1:0] stage;
    arr_t       disp;
    arr_t       twid;
    logic [3:0] upper;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] stage;
  arr_t       display_stream;
  arr_t       twiddle_stream;
  logic [3:0] upper_mask;
  logic       stage_err;

  int n_vec  = 0;
  int n_miss = 0;

  fft_stage_index_gen #(.SAMPLES(SAMPLES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stage          (stage),
    .display_stream (display_stream),
    .twiddle_stream (twiddle_stream),
    .upper_mask     (upper_mask),
    .stage_err      (stage_err)
  );

  always #5 clk = ~clk;

  // Build an array from positions listed in order [0,1,2,3].
  function automatic arr_t mk(input int a0, input int a1, input int a2, input int a3);
    arr_t r;
    r[0] = 2'(a0); r[1] = 2'(a1); r[2] = 2'(a2); r[3] = 2'(a3);
    return r;
  endfunction

  task automatic check(input string name, input arr_t ed, input arr_t et,
                       input logic [3:0] eu, input logic ee);
    n_vec++;
    if (display_stream !== ed) begin
      n_miss++;
      $display("FAIL %s display_stream got %h want %h", name, display_stream, ed);
    end
    if (twiddle_stream !== et) begin
      n_miss++;
      $display("FAIL %s twiddle_stream got %h want %h", name, twiddle_stream, et);
    end
    if (upper_mask !== eu) begin
      n_miss++;
      $display("FAIL %s upper_mask got %b want %b", name, upper_mask, eu);
    end
    if (stage_err !== ee) begin
      n_miss++;
      $display("FAIL %s stage_err got %b want %b", name, stage_err, ee);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] s);
    @(negedge clk);
    rst_n = r;
    stage = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arr_t id, z, d0, d1, t1;
    vec_t tbl[$];
    int cnt;

    id = mk(0, 1, 2, 3);
    z  = mk(0, 0, 0, 0);
    d0 = mk(1, 0, 3, 2);
    d1 = mk(2, 3, 0, 1);
    t1 = mk(0, 1, 0, 1);

    tbl.push_back('{1'b0, 2'd0, id, z,  4'b0000, 1'b0}); // reset, cycle 1
    tbl.push_back('{1'b0, 2'd1, id, z,  4'b0000, 1'b0}); // reset, cycle 2
    tbl.push_back('{1'b1, 2'd0, d0, z,  4'b0101, 1'b0}); // stage 0
    tbl.push_back('{1'b1, 2'd1, d1, t1, 4'b0011, 1'b0}); // stage 1
    tbl.push_back('{1'b1, 2'd3, d1, t1, 4'b0011, 1'b1}); // invalid holds
    tbl.push_back('{1'b1, 2'd2, d1, t1, 4'b0011, 1'b1}); // invalid holds
    tbl.push_back('{1'b1, 2'd0, d0, z,  4'b0101, 1'b0}); // recovery
    tbl.push_back('{1'b1, 2'd1, d1, t1, 4'b0011, 1'b0}); // toggle
    tbl.push_back('{1'b1, 2'd0, d0, z,  4'b0101, 1'b0});
    tbl.push_back('{1'b1, 2'd1, d1, t1, 4'b0011, 1'b0});
    tbl.push_back('{1'b0, 2'd1, id, z,  4'b0000, 1'b0}); // reset beats stage
    tbl.push_back('{1'b1, 2'd1, d1, t1, 4'b0011, 1'b0}); // reload after reset
    tbl.push_back('{1'b1, 2'd3, d1, t1, 4'b0011, 1'b1});
    tbl.push_back('{1'b0, 2'd3, id, z,  4'b0000, 1'b0}); // reset clears err
    tbl.push_back('{1'b1, 2'd2, id, z,  4'b0000, 1'b1}); // holds reset map
    tbl.push_back('{1'b1, 2'd0, d0, z,  4'b0101, 1'b0});

    rst_n = 1'b0;
    stage = 2'd0;

    for (int v = 0; v < tbl.size(); v++) begin
      step(tbl[v].rst_n, tbl[v].stage);
      check($sformatf("vec%0d", v), tbl[v].disp, tbl[v].twid, tbl[v].upper, tbl[v].err);
    end

    // Stage held for 100 time units, then changed mid-cycle: the old map must
    // persist up to the edge and the new one appear right after it.
    step(1'b1, 2'd0);
    #100;
    check("hold_s0", d0, z, 4'b0101, 1'b0);
    @(negedge clk);
    stage = 2'd1;
    @(posedge clk);
    #0;
    check("pre_edge_s0", d0, z, 4'b0101, 1'b0);
    #1;
    check("post_edge_s1", d1, t1, 4'b0011, 1'b0);

    // Partner map is an involution and half the positions are upper legs.
    for (int s = 0; s < LOG2; s++) begin
      step(1'b1, 2'(s));
      cnt = 0;
      for (int i = 0; i < SAMPLES; i++) begin
        n_vec++;
        if (display_stream[display_stream[i]] !== 2'(i)) begin
          n_miss++;
          $display("FAIL invol_s%0d_i%0d got %0d want %0d", s, i,
                   display_stream[display_stream[i]], i);
        end
        if (upper_mask[i] === 1'b1) cnt++;
      end
      n_vec++;
      if (cnt != SAMPLES / 2) begin
        n_miss++;
        $display("FAIL popcount_s%0d got %0d want %0d", s, cnt, SAMPLES / 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
